// File: rtl/pc_branch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_branch_unit_if
//  Purpose  : Bundles the control, operand and status signals exchanged
//             between the core sequencer and the PC / branch-resolution unit.
//             clk and reset stay outside the bundle as plain ports.
//  Modports : master - core side (drives requests, observes PC/status)
//             slave  - pc_branch_unit side
//  Signals  : stall, pc_adv, fetch_latch, tgt_latch, imm,
//             br_valid/br_ready, br_funct3, rs1, rs2,
//             jmp_valid, jmp_target,
//             pc, old_pc, redirect_done, taken, misalign_trap, fault_addr,
//             br_count, taken_count
//  Revision : 1.0  initial release
// ============================================================================
interface pc_branch_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) ();
  logic             stall;
  logic             pc_adv;
  logic             fetch_latch;
  logic             tgt_latch;
  logic [XLEN-1:0]  imm;
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_funct3;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic             jmp_valid;
  logic [XLEN-1:0]  jmp_target;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  old_pc;
  logic             redirect_done;
  logic             taken;
  logic             misalign_trap;
  logic [XLEN-1:0]  fault_addr;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output stall, pc_adv, fetch_latch, tgt_latch, imm,
    output br_valid, br_funct3, rs1, rs2, jmp_valid, jmp_target,
    input  br_ready, pc, old_pc, redirect_done, taken, misalign_trap,
    input  fault_addr, br_count, taken_count
  );

  modport slave (
    input  stall, pc_adv, fetch_latch, tgt_latch, imm,
    input  br_valid, br_funct3, rs1, rs2, jmp_valid, jmp_target,
    output br_ready, pc, old_pc, redirect_done, taken, misalign_trap,
    output fault_addr, br_count, taken_count
  );
endinterface
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_branch_unit
//  Purpose  : PC / branch-resolution unit for the multicycle RISC-V core.
//             Owns PC, OldPC and BranchTarget, resolves the B-type
//             conditions with a private comparator, clears JALR bit 0,
//             redirects misaligned targets to TRAP_VECTOR and keeps
//             saturating branch statistics.
//  Ports    : clk   - core clock
//             reset - synchronous, active-high reset
//             bus   - pc_branch_unit_if.slave (requests, operands, status)
//  Revision : 1.0  initial release
// ============================================================================
module pc_branch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 'h1000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h0100,
  parameter int              IALIGN       = 32,
  parameter int              CNT_W        = 16
) (
  input wire              clk,
  input wire              reset,
  pc_branch_unit_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EVAL = 1'b1
  } state_t;

  localparam logic [XLEN-1:0]  c_pc_step = XLEN'(4);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t           state_q,         state_d;
  logic [XLEN-1:0]  pc_q,            pc_d;
  logic [XLEN-1:0]  old_pc_q,        old_pc_d;
  logic [XLEN-1:0]  tgt_q,           tgt_d;
  logic [XLEN-1:0]  fault_addr_q,    fault_addr_d;
  logic [2:0]       funct3_q,        funct3_d;
  logic [XLEN-1:0]  rs1_q,           rs1_d;
  logic [XLEN-1:0]  rs2_q,           rs2_d;
  logic [CNT_W-1:0] br_count_q,      br_count_d;
  logic [CNT_W-1:0] taken_count_q,   taken_count_d;
  logic             redirect_done_q, redirect_done_d;
  logic             taken_q,         taken_d;
  logic             misalign_trap_q, misalign_trap_d;

  logic [XLEN-1:0]  w_align_mask;
  logic [XLEN-1:0]  w_jmp_target;
  logic             w_jmp_misaligned;
  logic             w_tgt_misaligned;
  logic             w_cond_taken;

  // Low address bits that must be zero for a legal instruction address.
  generate
    if (IALIGN == 16) begin : g_ialign16
      assign w_align_mask = {{(XLEN-1){1'b0}}, 1'b1};
    end else begin : g_ialign32
      assign w_align_mask = {{(XLEN-2){1'b0}}, 2'b11};
    end
  endgenerate

  // JALR semantics: bit 0 is cleared before the alignment check, so with
  // 16-bit alignment a jump can never trap.
  assign w_jmp_target     = {bus.jmp_target[XLEN-1:1], 1'b0};
  assign w_jmp_misaligned = |(w_jmp_target & w_align_mask);
  assign w_tgt_misaligned = |(tgt_q & w_align_mask);

  // Comparator works on the operands captured at acceptance so the
  // register file may move on while the branch is evaluated.
  always_comb begin
    w_cond_taken = 1'b0;
    case (funct3_q)
      3'b000:  w_cond_taken = (rs1_q == rs2_q);
      3'b001:  w_cond_taken = (rs1_q != rs2_q);
      3'b100:  w_cond_taken = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  w_cond_taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  w_cond_taken = (rs1_q <  rs2_q);
      3'b111:  w_cond_taken = (rs1_q >= rs2_q);
      default: w_cond_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    old_pc_d        = old_pc_q;
    tgt_d           = tgt_q;
    fault_addr_d    = fault_addr_q;
    funct3_d        = funct3_q;
    rs1_d           = rs1_q;
    rs2_d           = rs2_q;
    br_count_d      = br_count_q;
    taken_count_d   = taken_count_q;
    // Pulses hold while stalled so the consumer cannot miss them.
    redirect_done_d = redirect_done_q;
    taken_d         = taken_q;
    misalign_trap_d = misalign_trap_q;

    if (!bus.stall) begin
      redirect_done_d = 1'b0;
      taken_d         = 1'b0;
      misalign_trap_d = 1'b0;

      // tgt uses old_pc_q, i.e. the value before a same-cycle fetch_latch.
      if (bus.fetch_latch) old_pc_d = pc_q;
      if (bus.tgt_latch)   tgt_d    = old_pc_q + bus.imm;

      case (state_q)
        S_IDLE: begin
          if (bus.jmp_valid) begin
            redirect_done_d = 1'b1;
            taken_d         = 1'b1;
            if (w_jmp_misaligned) begin
              pc_d            = TRAP_VECTOR;
              fault_addr_d    = w_jmp_target;
              misalign_trap_d = 1'b1;
            end else begin
              pc_d = w_jmp_target;
            end
          end else if (bus.br_valid) begin
            funct3_d = bus.br_funct3;
            rs1_d    = bus.rs1;
            rs2_d    = bus.rs2;
            state_d  = S_EVAL;
          end else if (bus.pc_adv) begin
            pc_d = pc_q + c_pc_step;
          end
        end

        S_EVAL: begin
          state_d         = S_IDLE;
          redirect_done_d = 1'b1;
          taken_d         = w_cond_taken;
          if (br_count_q != {CNT_W{1'b1}}) br_count_d = br_count_q + c_cnt_one;
          if (w_cond_taken) begin
            if (taken_count_q != {CNT_W{1'b1}}) begin
              taken_count_d = taken_count_q + c_cnt_one;
            end
            if (w_tgt_misaligned) begin
              pc_d            = TRAP_VECTOR;
              fault_addr_d    = tgt_q;
              misalign_trap_d = 1'b1;
            end else begin
              pc_d = tgt_q;
            end
          end else begin
            pc_d = old_pc_q + c_pc_step;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_VECTOR;
      old_pc_q        <= RESET_VECTOR;
      tgt_q           <= '0;
      fault_addr_q    <= '0;
      funct3_q        <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      br_count_q      <= '0;
      taken_count_q   <= '0;
      redirect_done_q <= 1'b0;
      taken_q         <= 1'b0;
      misalign_trap_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      old_pc_q        <= old_pc_d;
      tgt_q           <= tgt_d;
      fault_addr_q    <= fault_addr_d;
      funct3_q        <= funct3_d;
      rs1_q           <= rs1_d;
      rs2_q           <= rs2_d;
      br_count_q      <= br_count_d;
      taken_count_q   <= taken_count_d;
      redirect_done_q <= redirect_done_d;
      taken_q         <= taken_d;
      misalign_trap_q <= misalign_trap_d;
    end
  end

  assign bus.br_ready      = (state_q == S_IDLE) & ~bus.jmp_valid & ~bus.stall;
  assign bus.pc            = pc_q;
  assign bus.old_pc        = old_pc_q;
  assign bus.redirect_done = redirect_done_q;
  assign bus.taken         = taken_q;
  assign bus.misalign_trap = misalign_trap_q;
  assign bus.fault_addr    = fault_addr_q;
  assign bus.br_count      = br_count_q;
  assign bus.taken_count   = taken_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_branch_unit
//  Purpose  : Self-checking bench for pc_branch_unit. Two instances share
//             one stimulus stream: a 16-bit-counter unit and a 2-bit-counter
//             unit (for saturation). A behavioural model tracks the
//             architectural effect of each request; directed scenarios pin
//             the model with literal values, then random traffic follows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_branch_unit;
  localparam logic [31:0] RV = 32'h0000_1000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pc_branch_unit_if #(.XLEN(32), .CNT_W(16)) bus_a ();
  pc_branch_unit_if #(.XLEN(32), .CNT_W(2))  bus_b ();

  assign bus_b.stall       = bus_a.stall;
  assign bus_b.pc_adv      = bus_a.pc_adv;
  assign bus_b.fetch_latch = bus_a.fetch_latch;
  assign bus_b.tgt_latch   = bus_a.tgt_latch;
  assign bus_b.imm         = bus_a.imm;
  assign bus_b.br_valid    = bus_a.br_valid;
  assign bus_b.br_funct3   = bus_a.br_funct3;
  assign bus_b.rs1         = bus_a.rs1;
  assign bus_b.rs2         = bus_a.rs2;
  assign bus_b.jmp_valid   = bus_a.jmp_valid;
  assign bus_b.jmp_target  = bus_a.jmp_target;

  pc_branch_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV),
                   .IALIGN(32), .CNT_W(16))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  pc_branch_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV),
                   .IALIGN(32), .CNT_W(2))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_old, m_tgt, m_fault, m_a, m_b;
  logic [2:0]  m_f3;
  bit          m_eval, m_done, m_taken, m_trap, m_live;
  int          m_nbr, m_ntk;

  initial m_live = 1'b0;

  function automatic bit br_cond(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
    longint sa, sb;
    sa = (a >= 32'h8000_0000) ? longint'(a) - 64'sd4294967296 : longint'(a);
    sb = (b >= 32'h8000_0000) ? longint'(b) - 64'sd4294967296 : longint'(b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_redirect(input logic [31:0] t);
    m_done  = 1'b1;
    m_taken = 1'b1;
    if (t % 4 != 0) begin
      m_pc    = TV;
      m_fault = t;
      m_trap  = 1'b1;
    end else begin
      m_pc = t;
    end
  endtask

  task automatic model_step();
    logic [31:0] pc0, old0, tgt0;
    if (reset) begin
      m_pc = RV; m_old = RV; m_tgt = '0; m_fault = '0;
      m_eval = 1'b0; m_nbr = 0; m_ntk = 0;
      m_done = 1'b0; m_taken = 1'b0; m_trap = 1'b0;
      m_live = 1'b1;
    end else if (m_live && !bus_a.stall) begin
      pc0 = m_pc; old0 = m_old; tgt0 = m_tgt;
      m_done = 1'b0; m_taken = 1'b0; m_trap = 1'b0;
      if (bus_a.fetch_latch) m_old = pc0;
      if (bus_a.tgt_latch)   m_tgt = old0 + bus_a.imm;
      if (!m_eval) begin
        if (bus_a.jmp_valid) begin
          model_redirect(bus_a.jmp_target & 32'hFFFF_FFFE);
        end else if (bus_a.br_valid) begin
          m_eval = 1'b1;
          m_f3 = bus_a.br_funct3; m_a = bus_a.rs1; m_b = bus_a.rs2;
        end else if (bus_a.pc_adv) begin
          m_pc = pc0 + 32'd4;
        end
      end else begin
        m_eval = 1'b0;
        m_nbr++;
        if (br_cond(m_f3, m_a, m_b)) begin
          m_ntk++;
          model_redirect(tgt0);
        end else begin
          m_done = 1'b1;
          m_pc   = old0 + 32'd4;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("pc",            bus_a.pc,            m_pc);
    chk("old_pc",        bus_a.old_pc,        m_old);
    chk("fault_addr",    bus_a.fault_addr,    m_fault);
    chk("br_ready",      32'(bus_a.br_ready),
        32'(!m_eval && !bus_a.jmp_valid && !bus_a.stall));
    chk("redirect_done", 32'(bus_a.redirect_done), 32'(m_done));
    chk("misalign_trap", 32'(bus_a.misalign_trap), 32'(m_trap));
    if (m_done) chk("taken", 32'(bus_a.taken), 32'(m_taken));
    chk("br_count16",    32'(bus_a.br_count),    sat(m_nbr, 16));
    chk("taken_count16", 32'(bus_a.taken_count), sat(m_ntk, 16));
    chk("br_count2",     32'(bus_b.br_count),    sat(m_nbr, 2));
    chk("taken_count2",  32'(bus_b.taken_count), sat(m_ntk, 2));
    chk("pc_cnt2_inst",  bus_b.pc,               m_pc);
  endtask

  // Single compare process: advance the model on each edge, check shortly after.
  always @(posedge clk) begin
    model_step();
    #1;
    if (m_live) compare();
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus_a.stall = 1'b0; bus_a.pc_adv = 1'b0; bus_a.fetch_latch = 1'b0;
    bus_a.tgt_latch = 1'b0; bus_a.imm = '0; bus_a.br_valid = 1'b0;
    bus_a.br_funct3 = '0; bus_a.rs1 = '0; bus_a.rs2 = '0;
    bus_a.jmp_valid = 1'b0; bus_a.jmp_target = '0;
  endtask

  task automatic branch(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    bus_a.br_valid = 1'b1; bus_a.br_funct3 = f; bus_a.rs1 = a; bus_a.rs2 = b;
    step();
    bus_a.br_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    step();
    step();

    // 1: reset state
    chk("T1 pc", bus_a.pc, 32'h1000);
    chk("T1 old_pc", bus_a.old_pc, 32'h1000);
    chk("T1 br_ready", 32'(bus_a.br_ready), 32'd1);
    chk("T1 br_count", 32'(bus_a.br_count), 32'd0);
    chk("T1 done", 32'(bus_a.redirect_done), 32'd0);
    reset = 1'b0;

    // 2: BEQ taken, tgt latched in the acceptance cycle
    bus_a.tgt_latch = 1'b1; bus_a.imm = 32'h20;
    branch(3'b000, 32'd5, 32'd5);
    bus_a.tgt_latch = 1'b0;
    chk("T2 pc_before", bus_a.pc, 32'h1000);
    step();
    chk("T2 pc", bus_a.pc, 32'h1020);
    chk("T2 taken", 32'(bus_a.taken), 32'd1);
    chk("T2 done", 32'(bus_a.redirect_done), 32'd1);
    chk("T2 counts", {16'(bus_a.br_count), 16'(bus_a.taken_count)}, 32'h0001_0001);

    // 3: signed vs unsigned less-than
    branch(3'b100, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("T3 blt pc", bus_a.pc, 32'h1020);
    chk("T3 blt taken", 32'(bus_a.taken), 32'd1);
    branch(3'b110, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("T3 bltu pc", bus_a.pc, 32'h1004);
    chk("T3 bltu taken", 32'(bus_a.taken), 32'd0);
    chk("T3 counts", {16'(bus_a.br_count), 16'(bus_a.taken_count)}, 32'h0003_0002);

    // 4: jump beats branch; misaligned target traps
    bus_a.jmp_valid = 1'b1; bus_a.br_valid = 1'b1; bus_a.jmp_target = 32'h2003;
    #1;
    chk("T4 br_ready", 32'(bus_a.br_ready), 32'd0);
    step();
    clear_inputs();
    chk("T4 pc", bus_a.pc, 32'h0100);
    chk("T4 fault", bus_a.fault_addr, 32'h2002);
    chk("T4 trap", 32'(bus_a.misalign_trap), 32'd1);
    step();
    chk("T4 trap_end", 32'(bus_a.misalign_trap), 32'd0);
    chk("T4 counts", 32'(bus_a.br_count), 32'd3);

    // 5: reset during EVAL aborts the branch
    branch(3'b000, 32'd9, 32'd9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("T5 pc", bus_a.pc, 32'h1000);
    chk("T5 count", 32'(bus_a.br_count), 32'd0);
    chk("T5 done", 32'(bus_a.redirect_done), 32'd0);

    // 6: stall mid-EVAL, pulse hold, counter saturation
    bus_a.tgt_latch = 1'b1; bus_a.imm = 32'h40;
    branch(3'b000, 32'd7, 32'd7);
    bus_a.tgt_latch = 1'b0;
    bus_a.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("T6 stall pc", bus_a.pc, 32'h1000);
    end
    bus_a.stall = 1'b0;
    step();
    chk("T6 pc", bus_a.pc, 32'h1040);
    for (int i = 0; i < 4; i++) begin
      branch(3'b000, 32'd7, 32'd7);
      step();
      if (i == 0) begin
        bus_a.stall = 1'b1;
        step();
        chk("T6 pulse hold", 32'(bus_a.redirect_done), 32'd1);
        bus_a.stall = 1'b0;
        step();
        chk("T6 pulse end", 32'(bus_a.redirect_done), 32'd0);
      end
    end
    chk("T6 br16", 32'(bus_a.br_count), 32'd5);
    chk("T6 tk16", 32'(bus_a.taken_count), 32'd5);
    chk("T6 br2", 32'(bus_b.br_count), 32'd3);
    chk("T6 tk2", 32'(bus_b.taken_count), 32'd3);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset             = ($urandom_range(0, 79) == 0);
      bus_a.stall       = ($urandom_range(0, 7) == 0);
      bus_a.pc_adv      = $urandom_range(0, 1) == 1;
      bus_a.fetch_latch = ($urandom_range(0, 2) == 0);
      bus_a.tgt_latch   = ($urandom_range(0, 3) == 0);
      bus_a.imm         = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                          : 32'($urandom_range(0, 255)) << 2;
      bus_a.br_valid    = ($urandom_range(0, 2) == 0);
      bus_a.br_funct3   = 3'($urandom_range(0, 7));
      bus_a.rs1         = pick_op();
      bus_a.rs2         = ($urandom_range(0, 2) == 0) ? bus_a.rs1 : pick_op();
      bus_a.jmp_valid   = ($urandom_range(0, 9) == 0);
      bus_a.jmp_target  = 32'($urandom);
      step();
    end
    reset = 1'b0;
    clear_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
